// File: rtl/traffic_light_fsm.sv
// Two-road intersection controller: main road rests on green until a side-road or pedestrian
// request arrives, then cycles through yellow, all-red, side green, yellow, all-red.
module traffic_light_fsm #(
  parameter int unsigned T_MG = 10,
  parameter int unsigned T_Y  = 3,
  parameter int unsigned T_AR = 1,
  parameter int unsigned T_SG = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       side_req,
  input  logic       ped_btn,
  output logic [2:0] main_rgy,
  output logic [2:0] side_rgy,
  output logic       walk,
  output logic [3:0] time_left,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StMg  = 3'd0,
    StMy  = 3'd1,
    StAr1 = 3'd2,
    StSg  = 3'd3,
    StSy  = 3'd4,
    StAr2 = 3'd5
  } state_e;

  localparam logic [3:0] LdMg = 4'(T_MG - 1);
  localparam logic [3:0] LdY  = 4'(T_Y - 1);
  localparam logic [3:0] LdAr = 4'(T_AR - 1);
  localparam logic [3:0] LdSg = 4'(T_SG - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic       req_latch_q, req_latch_d;
  logic       ped_pend_q, ped_pend_d;
  logic       walk_q, walk_d;
  logic [2:0] main_rgy_q, main_rgy_d;
  logic [2:0] side_rgy_q, side_rgy_d;

  logic expired;
  logic req_any;

  assign expired = tick && (timer_q == 4'd0);
  assign req_any = req_latch_q | side_req | ped_btn;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    req_latch_d = req_latch_q | side_req | ped_btn;
    ped_pend_d  = ped_pend_q | ped_btn;
    walk_d      = walk_q;

    if (tick && (timer_q != 4'd0)) begin
      timer_d = timer_q - 4'd1;
    end

    case (state_q)
      StMg: begin
        // Main green rests at zero until someone asks for the side phase.
        if (expired && req_any) begin
          state_d = StMy;
          timer_d = LdY;
        end
      end
      StMy: begin
        if (expired) begin
          state_d = StAr1;
          timer_d = LdAr;
        end
      end
      StAr1: begin
        if (expired) begin
          state_d     = StSg;
          timer_d     = LdSg;
          req_latch_d = 1'b0;
          walk_d      = ped_pend_q | ped_btn;
          ped_pend_d  = 1'b0;
        end
      end
      StSg: begin
        if (expired) begin
          state_d = StSy;
          timer_d = LdY;
          walk_d  = 1'b0;
        end
      end
      StSy: begin
        if (expired) begin
          state_d = StAr2;
          timer_d = LdAr;
        end
      end
      StAr2: begin
        if (expired) begin
          state_d = StMg;
          timer_d = LdMg;
        end
      end
      default: begin
        state_d = StMg;
        timer_d = LdMg;
        walk_d  = 1'b0;
      end
    endcase
  end

  // Lamps decode from the next state so they update on the same edge as the state register.
  always_comb begin
    main_rgy_d = 3'b100;
    side_rgy_d = 3'b100;
    case (state_d)
      StMg:    main_rgy_d = 3'b001;
      StMy:    main_rgy_d = 3'b010;
      StSg:    side_rgy_d = 3'b001;
      StSy:    side_rgy_d = 3'b010;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StMg;
      timer_q     <= LdMg;
      req_latch_q <= 1'b0;
      ped_pend_q  <= 1'b0;
      walk_q      <= 1'b0;
      main_rgy_q  <= 3'b001;
      side_rgy_q  <= 3'b100;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      req_latch_q <= req_latch_d;
      ped_pend_q  <= ped_pend_d;
      walk_q      <= walk_d;
      main_rgy_q  <= main_rgy_d;
      side_rgy_q  <= side_rgy_d;
    end
  end

  assign main_rgy  = main_rgy_q;
  assign side_rgy  = side_rgy_q;
  assign walk      = walk_q;
  assign time_left = timer_q;
  assign state     = state_q;

endmodule
